// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants and types for the EX-stage branch resolution unit.
package branch_resolve_unit_pkg;

  localparam int PHT_IDX_W_DEF = 3;

  // Branch condition codes (funct3)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Flush encodings; IFID-only flush is issued by the predictor, not here
  localparam logic [1:0] FLUSH_NONE = 2'b00;
  localparam logic [1:0] FLUSH_IFID = 2'b01;
  localparam logic [1:0] FLUSH_ALL  = 2'b11;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_compare.sv
// Combinational branch condition evaluator: funct3/rs1/rs2 -> taken, illegal.
module branch_compare
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            taken_o,
  output logic            illegal_o
);

  logic eq, lt_s, lt_u;

  assign eq   = (rs1_i == rs2_i);
  assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
  assign lt_u = (rs1_i < rs2_i);

  // Select the condition; illegal codes resolve not-taken
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = !eq;
      F3_BLT:  taken_o = lt_s;
      F3_BGE:  taken_o = !lt_s;
      F3_BLTU: taken_o = lt_u;
      F3_BGEU: taken_o = !lt_u;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/JALR resolution with one-cycle redirect+flush on mispredict
// and a MEM-stage training pulse for the predictor.
// Optional perf counters enabled by macro BRU_PERF_EN.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PHT_IDX_W = PHT_IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 valid_ex,
  input  logic                 branch_ex,
  input  logic                 jalr_ex,
  input  logic [2:0]           funct3_ex,
  input  logic [XLEN-1:0]      rs1_val,
  input  logic [XLEN-1:0]      rs2_val,
  input  logic [XLEN-1:0]      pc_ex,
  input  logic [XLEN-1:0]      imm_ex,
  input  logic                 pred_taken_ex,
  input  logic [PHT_IDX_W-1:0] pht_index_ex,
  output logic                 branch_resolved,
  output logic                 actual_taken,
  output logic [PHT_IDX_W-1:0] pht_indexMEM,
  output logic                 redirect,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [1:0]           flush
`ifdef BRU_PERF_EN
  , output logic [31:0]        br_count
  , output logic [31:0]        mispred_count
`endif
);

  bru_state_e           state_q, state_d;
  logic [XLEN-1:0]      rpc_q, rpc_d;
  logic                 res_q, act_q;
  logic [PHT_IDX_W-1:0] idx_q;

  logic            taken, illegal;
  logic            accept, is_br, resolve, mispred, jalr_acc;
  logic [XLEN-1:0] taken_pc, fall_pc, jalr_sum, jalr_pc;

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .funct3_i  (funct3_ex),
    .rs1_i     (rs1_val),
    .rs2_i     (rs2_val),
    .taken_o   (taken),
    .illegal_o (illegal)
  );

  // While redirecting, the EX slot is wrong-path and must not be consumed
  assign accept   = valid_ex & !stall & (state_q == IDLE);
  // JALR wins if both flags are set, so it never trains the PHT
  assign is_br    = branch_ex & !jalr_ex;
  assign resolve  = accept & is_br;
  assign mispred  = resolve & !illegal & (taken != pred_taken_ex);
  assign jalr_acc = accept & jalr_ex;

  assign taken_pc = pc_ex + imm_ex;
  assign fall_pc  = pc_ex + XLEN'(4);
  assign jalr_sum = rs1_val + imm_ex;
  assign jalr_pc  = {jalr_sum[XLEN-1:1], 1'b0};

  // Next state, latched target and registered outputs
  always_comb begin
    state_d  = IDLE;
    rpc_d    = rpc_q;
    redirect = 1'b0;
    flush    = FLUSH_NONE;
    if (state_q == REDIRECT) begin
      redirect = 1'b1;
      flush    = FLUSH_ALL;
    end else if (mispred) begin
      state_d = REDIRECT;
      rpc_d   = taken ? taken_pc : fall_pc;
    end else if (jalr_acc) begin
      state_d = REDIRECT;
      rpc_d   = jalr_pc;
    end
  end

  // State, redirect target and MEM-stage resolution registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rpc_q   <= '0;
      res_q   <= 1'b0;
      act_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rpc_q   <= rpc_d;
      res_q   <= resolve;
      if (resolve) begin
        act_q <= taken;
        idx_q <= pht_index_ex;
      end
    end
  end

  assign branch_resolved = res_q;
  assign actual_taken    = act_q;
  assign pht_indexMEM    = idx_q;
  assign redirect_pc     = rpc_q;

`ifdef BRU_PERF_EN
  logic [31:0] brc_q, mpc_q;

  // Saturating branch / mispredict counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brc_q <= '0;
      mpc_q <= '0;
    end else begin
      if (resolve && brc_q != 32'hFFFF_FFFF) brc_q <= brc_q + 32'd1;
      if (mispred && mpc_q != 32'hFFFF_FFFF) mpc_q <= mpc_q + 32'd1;
    end
  end

  assign br_count      = brc_q;
  assign mispred_count = mpc_q;
`endif

endmodule
